// File: rtl/bridge_target_cmd.sv
// Core-to-host target command initiator: the core posts a command word and parameters into
// a bridge-visible mailbox, and the host acknowledges and then completes it with a result.
module bridge_target_cmd #(
  parameter logic [31:0] BASE_ADDR      = 32'hF800_2000,
  parameter int unsigned NPARAM         = 4,
  parameter int unsigned NRESP          = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [15:0]                              req_word,
  input  logic [32*NPARAM-1:0]                     req_param,
  output logic                                     done,
  output logic [15:0]                              result,
  output logic [32*((NRESP > 0) ? NRESP : 1)-1:0]  response,
  output logic                                     timed_out,
  output logic                                     busy,
  input  logic [31:0]                              bridge_addr,
  input  logic                                     bridge_wr,
  input  logic [31:0]                              bridge_wr_data,
  input  logic                                     bridge_rd,
  output logic [31:0]                              bridge_rd_data
);

  localparam int unsigned RESP_N    = (NRESP > 0) ? NRESP : 1;
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(64'(TIMEOUT_CYCLES) + 64'd1) : 1;
  localparam int unsigned RESP_BASE = 16;
  localparam logic [15:0] PFX_POST  = 16'h636D;
  localparam logic [15:0] PFX_ACK   = 16'h706E;
  localparam logic [15:0] PFX_OK    = 16'h6F6B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POST,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_RESPOND
  } state_t;

  state_t             state_q, state_nxt;
  logic [31:0]        status_q;
  logic [15:0]        cmd_q;
  logic [31:0]        param_q [NPARAM];
  logic [31:0]        resp_q  [RESP_N];
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rd_mux;

  logic               hit, wr_status, waiting, accept;
  logic               host_ack, host_ok, resp_wr, tmo_hit;
  logic [5:0]         widx;
  logic [15:0]        wr_prefix;
  logic [1:0]         unused_addr_lsb;

  // Mailbox decode
  assign unused_addr_lsb = bridge_addr[1:0];
  assign hit       = (bridge_addr[31:8] == BASE_ADDR[31:8]);
  assign widx      = bridge_addr[7:2];
  assign wr_prefix = bridge_wr_data[31:16];
  assign wr_status = bridge_wr & hit & (widx == 6'd0);
  assign waiting   = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);
  assign accept    = req_valid & (state_q == ST_IDLE);
  assign host_ack  = wr_status & (wr_prefix == PFX_ACK) & (state_q == ST_WAIT_ACK);
  assign host_ok   = wr_status & (wr_prefix == PFX_OK) & waiting;
  assign resp_wr   = bridge_wr & hit & waiting;
  // A host ack/ok landing on the expiry cycle takes priority over the timeout
  assign tmo_hit   = (TIMEOUT_CYCLES != 32'd0) && (state_q == ST_WAIT_ACK) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1)) && !host_ack && !host_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_nxt = ST_POST;
      ST_POST:      state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (host_ok)       state_nxt = ST_RESPOND;
        else if (host_ack) state_nxt = ST_WAIT_DONE;
        else if (tmo_hit)  state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (host_ok) state_nxt = ST_RESPOND;
      ST_RESPOND:   state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Read mux sees the pre-write register contents
  always_comb begin
    rd_mux = 32'd0;
    if (hit) begin
      if (widx == 6'd0) rd_mux = status_q;
      for (int i = 0; i < NPARAM; i++)
        if (widx == 6'(i + 1)) rd_mux = param_q[i];
      for (int i = 0; i < NRESP; i++)
        if (widx == 6'(RESP_BASE + i)) rd_mux = resp_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q       <= 32'd0;
      cmd_q          <= 16'd0;
      cnt_q          <= '0;
      done           <= 1'b0;
      timed_out      <= 1'b0;
      busy           <= 1'b0;
      req_ready      <= 1'b1;
      result         <= 16'd0;
      response       <= '0;
      bridge_rd_data <= 32'd0;
      for (int i = 0; i < NPARAM; i++) param_q[i] <= 32'd0;
      for (int i = 0; i < RESP_N; i++) resp_q[i] <= 32'd0;
    end else begin
      done      <= 1'b0;
      timed_out <= 1'b0;
      busy      <= (state_nxt != ST_IDLE);
      req_ready <= (state_nxt == ST_IDLE);
      if (bridge_rd) bridge_rd_data <= rd_mux;

      if (accept) begin
        cmd_q <= req_word;
        for (int i = 0; i < NPARAM; i++) param_q[i] <= req_param[32*i +: 32];
        for (int i = 0; i < RESP_N; i++) resp_q[i] <= 32'd0;
      end

      if (state_q == ST_POST) begin
        status_q <= {PFX_POST, cmd_q};
        cnt_q    <= '0;
      end else if (state_q == ST_WAIT_ACK && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      for (int i = 0; i < NRESP; i++)
        if (resp_wr && widx == 6'(RESP_BASE + i)) resp_q[i] <= bridge_wr_data;

      if (host_ack) status_q <= bridge_wr_data;

      // Completion: host ok or timeout both clear the mailbox and pulse done
      if (host_ok || tmo_hit) begin
        status_q  <= 32'd0;
        done      <= 1'b1;
        timed_out <= tmo_hit;
        result    <= host_ok ? bridge_wr_data[15:0] : 16'hFFFF;
        for (int i = 0; i < RESP_N; i++) response[32*i +: 32] <= resp_q[i];
      end
    end
  end

endmodule

// File: tb/tb_bridge_target_cmd.sv
// Bench for bridge_target_cmd: directed scenarios plus randomized commands checked
// against a timing/outcome model built from the mailbox protocol rules.
module tb_bridge_target_cmd;

  localparam int unsigned NPARAM = 4;
  localparam int unsigned NRESP  = 2;
  localparam int unsigned TMO    = 16;
  localparam logic [31:0] BASE   = 32'hF800_2000;
  localparam logic [31:0] ACK    = 32'h706E_0000;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [15:0]           req_word;
  logic [32*NPARAM-1:0]  req_param;
  logic                  done;
  logic [15:0]           result;
  logic [32*NRESP-1:0]   response;
  logic                  timed_out;
  logic                  busy;
  logic [31:0]           bridge_addr;
  logic                  bridge_wr;
  logic [31:0]           bridge_wr_data;
  logic                  bridge_rd;
  logic [31:0]           bridge_rd_data;

  always #5 clk = ~clk;

  bridge_target_cmd #(
    .BASE_ADDR(BASE), .NPARAM(NPARAM), .NRESP(NRESP), .TIMEOUT_CYCLES(32'(TMO))
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_word(req_word), .req_param(req_param), .done(done), .result(result),
    .response(response), .timed_out(timed_out), .busy(busy), .bridge_addr(bridge_addr),
    .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
    .bridge_rd_data(bridge_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0]         seen_result = 16'd0;
  logic                seen_tmo = 1'b0;
  logic [32*NRESP-1:0] seen_resp = '0;

  // Completion monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      seen_result = result;
      seen_tmo    = timed_out;
      seen_resp   = response;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bwrite_addr(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
    tick();
    bridge_wr = 1'b0;
  endtask

  task automatic bwrite(input int w, input logic [31:0] d);
    bwrite_addr(BASE | 32'(w << 2), d);
  endtask

  task automatic bread_addr(input logic [31:0] a, output logic [31:0] d);
    bridge_addr = a; bridge_rd = 1'b1;
    tick();
    bridge_rd = 1'b0;
    d = bridge_rd_data;
  endtask

  task automatic bread(input int w, output logic [31:0] d);
    bread_addr(BASE | 32'(w << 2), d);
  endtask

  // Leaves the DUT one cycle past POST (first WAIT_ACK cycle)
  task automatic issue(input logic [15:0] cmd, input logic [32*NPARAM-1:0] p);
    req_word = cmd; req_param = p; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_word = '0; req_param = '0;
    bridge_addr = '0; bridge_wr = 1'b0; bridge_wr_data = '0; bridge_rd = 1'b0;
    #23;
    checks++;
    if ({busy, done, timed_out, result, bridge_rd_data} !== 51'd0) begin
      errors++; $display("FAIL reset_outputs: busy=%b done=%b tmo=%b result=%h rd=%h, required all 0",
                         busy, done, timed_out, result, bridge_rd_data);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    int d0;
    issue(16'h0180, {32'd4, 32'd3, 32'd2, 32'd1});
    bread(0, rd);
    checks++;
    if (rd !== 32'h636D_0180) begin errors++; $display("FAIL basic_posted: got %h required 636d0180", rd); end
    for (int i = 1; i <= 4; i++) begin
      bread(i, rd);
      checks++;
      if (rd !== 32'(i)) begin errors++; $display("FAIL basic_param%0d: got %h required %h", i, rd, i); end
    end
    bwrite(0, ACK);
    d0 = done_cnt;
    bwrite(0, 32'h6F6B_0000);
    checks++;
    if ({done, req_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_done_cycle: done=%b req_ready=%b required 1,0", done, req_ready);
    end
    tick();
    checks++;
    if ({done, req_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL basic_ready_cycle: done=%b req_ready=%b busy=%b required 0,1,0", done, req_ready, busy);
    end
    checks++;
    if (done_cnt != d0 + 1 || seen_result !== 16'd0 || seen_tmo !== 1'b0) begin
      errors++; $display("FAIL basic_result: pulses=%0d result=%h tmo=%b required 1,0000,0", done_cnt - d0, seen_result, seen_tmo);
    end
    bread(0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL basic_status_cleared: got %h required 0", rd); end
  endtask

  task automatic test_response();
    logic [31:0] rd;
    int d0;
    issue(16'h0222, {4{$urandom()}});
    bread(16, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL resp_cleared_on_accept: got %h required 0", rd); end
    bwrite(16, 32'hDEAD_BEEF);
    bwrite(17, 32'd5);
    bread(16, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL resp_readback: got %h required deadbeef", rd); end
    d0 = done_cnt;
    bwrite(0, 32'h6F6B_0003);
    tick();
    checks++;
    if (done_cnt != d0 + 1 || seen_result !== 16'd3 || seen_resp !== {32'd5, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL resp_values: pulses=%0d result=%h resp=%h required 1,0003,00000005deadbeef",
                         done_cnt - d0, seen_result, seen_resp);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int d0, first;
    d0 = done_cnt; first = -1;
    issue(16'h0333, '0);
    for (int i = 1; i <= int'(TMO) + 4; i++) begin
      tick();
      if (done === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != int'(TMO)) begin errors++; $display("FAIL tmo_latency: done after %0d cycles required %0d", first, TMO); end
    checks++;
    if (done_cnt != d0 + 1 || seen_result !== 16'hFFFF || seen_tmo !== 1'b1) begin
      errors++; $display("FAIL tmo_result: pulses=%0d result=%h tmo=%b required 1,ffff,1", done_cnt - d0, seen_result, seen_tmo);
    end
    bread(0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL tmo_status: got %h required 0", rd); end
    // Ack on the expiry cycle, then host silence must not time out
    d0 = done_cnt;
    issue(16'h0444, '0);
    repeat (TMO - 1) tick();
    bwrite(0, ACK);
    repeat (40) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      errors++; $display("FAIL ack_no_timeout: pulses=%0d busy=%b required 0,1", done_cnt - d0, busy);
    end
    bwrite(0, 32'h6F6B_0042);
    tick();
    checks++;
    if (done_cnt != d0 + 1 || seen_result !== 16'h0042 || seen_tmo !== 1'b0) begin
      errors++; $display("FAIL ack_then_ok: pulses=%0d result=%h tmo=%b required 1,0042,0", done_cnt - d0, seen_result, seen_tmo);
    end
  endtask

  task automatic test_race();
    int d0;
    d0 = done_cnt;
    issue(16'h0555, '0);
    repeat (TMO - 1) tick();
    bwrite(0, 32'h6F6B_00A5);
    tick();
    checks++;
    if (done_cnt != d0 + 1 || seen_result !== 16'h00A5 || seen_tmo !== 1'b0) begin
      errors++; $display("FAIL race_host_wins: pulses=%0d result=%h tmo=%b required 1,00a5,0", done_cnt - d0, seen_result, seen_tmo);
    end
  endtask

  task automatic test_abuse();
    logic [31:0] rd;
    int d0;
    issue(16'h0666, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    bwrite(0, 32'h1234_5678);
    bread(0, rd);
    checks++;
    if (rd !== 32'h636D_0666) begin errors++; $display("FAIL abuse_bad_prefix: got %h required 636d0666", rd); end
    bwrite(1, 32'hFFFF_FFFF);
    bread(1, rd);
    checks++;
    if (rd !== 32'hA0) begin errors++; $display("FAIL abuse_param_ro: got %h required 000000a0", rd); end
    bread(40, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL abuse_w40: got %h required 0", rd); end
    bread_addr(32'hF800_3000, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL abuse_unmapped: got %h required 0", rd); end
    bwrite(0, 32'h6F6B_0001);
    tick();
    d0 = done_cnt;
    bwrite(0, 32'h6F6B_0009);
    bwrite(16, 32'h1111_1111);
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL abuse_ok_in_idle: pulses=%0d busy=%b required 0,0", done_cnt - d0, busy);
    end
    bread(16, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL abuse_resp_in_idle: got %h required 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int d0;
    issue(16'h0777, '0);
    bwrite(0, ACK);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_mid_busy: busy=%b done=%b required 0,0", busy, done); end
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    bread(0, rd);
    checks++;
    if (rd !== 32'd0 || done_cnt != d0) begin
      errors++; $display("FAIL rst_mid_cleared: status=%h pulses=%0d required 0,0", rd, done_cnt - d0);
    end
    issue(16'h0888, '0);
    bwrite(0, 32'h6F6B_0007);
    tick();
    checks++;
    if (done_cnt != d0 + 1 || seen_result !== 16'h0007) begin
      errors++; $display("FAIL rst_mid_next: pulses=%0d result=%h required 1,0007", done_cnt - d0, seen_result);
    end
  endtask

  // Random commands: host acts after a random idle gap; model predicts host vs timeout outcome
  task automatic test_random();
    logic [31:0] rd, r0, r1, okw;
    logic [15:0] cmd;
    logic [32*NPARAM-1:0] p;
    int d0, gap, elapsed;
    bit use_ack, exp_tmo;
    for (int it = 0; it < 24; it++) begin
      cmd = 16'($urandom());
      for (int i = 0; i < int'(NPARAM); i++) p[32*i +: 32] = $urandom();
      r0 = $urandom(); r1 = $urandom(); okw = {16'h6F6B, 16'($urandom())};
      gap = $urandom_range(0, 12); use_ack = 1'($urandom());
      d0 = done_cnt;
      issue(cmd, p);
      bread(0, rd);
      checks++;
      if (rd !== {16'h636D, cmd}) begin errors++; $display("FAIL rnd%0d_posted: got %h required %h", it, rd, {16'h636D, cmd}); end
      for (int i = 1; i <= int'(NPARAM); i++) begin
        bread(i, rd);
        checks++;
        if (rd !== p[32*(i-1) +: 32]) begin errors++; $display("FAIL rnd%0d_param%0d: got %h required %h", it, i, rd, p[32*(i-1) +: 32]); end
      end
      bwrite(16, r0);
      bwrite(17, r1);
      repeat (gap) tick();
      elapsed = 1 + int'(NPARAM) + 2 + gap;
      exp_tmo = (elapsed >= int'(TMO));
      if (!exp_tmo) begin
        if (use_ack) bwrite(0, ACK);
        bwrite(0, okw);
      end
      tick();
      checks++;
      if (exp_tmo) begin
        if (done_cnt != d0 + 1 || seen_tmo !== 1'b1 || seen_result !== 16'hFFFF || busy !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_timeout: pulses=%0d tmo=%b result=%h busy=%b required 1,1,ffff,0",
                             it, done_cnt - d0, seen_tmo, seen_result, busy);
        end
      end else begin
        if (done_cnt != d0 + 1 || seen_tmo !== 1'b0 || seen_result !== okw[15:0] || seen_resp !== {r1, r0}) begin
          errors++; $display("FAIL rnd%0d_host: pulses=%0d tmo=%b result=%h resp=%h required 1,0,%h,%h",
                             it, done_cnt - d0, seen_tmo, seen_result, seen_resp, okw[15:0], {r1, r0});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_response();
    test_timeout();
    test_race();
    test_abuse();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
